// File: rtl/alu_seq_ctrl_if.sv
// Bundle of the request, unit and response signals around the ALU sequencing controller.
// Both handshakes (req, rsp) transfer on a rising clk edge where valid && ready; valid holds until then.
interface alu_seq_ctrl_if;
  logic         req_valid;
  logic         req_ready;
  logic [3:0]   req_dtype;
  logic [4:0]   req_operator;
  logic [15:0]  req_src1;
  logic [15:0]  req_src2;
  logic [15:0]  unit_src1;
  logic [15:0]  unit_src2;
  logic [5:0]   unit_start;
  logic [5:0]   unit_done;
  logic [191:0] unit_res;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [31:0]  rsp_res;
  logic [1:0]   rsp_err;

  modport slave (
    input  req_valid, req_dtype, req_operator, req_src1, req_src2,
    output req_ready,
    output unit_src1, unit_src2, unit_start,
    input  unit_done, unit_res,
    output rsp_valid, rsp_res, rsp_err,
    input  rsp_ready
  );

  modport master (
    output req_valid, req_dtype, req_operator, req_src1, req_src2,
    input  req_ready,
    input  unit_src1, unit_src2, unit_start,
    output unit_done, unit_res,
    input  rsp_valid, rsp_res, rsp_err,
    output rsp_ready
  );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Sequences one parsed calculator request through the selected arithmetic unit,
// with a done timeout, and hands a registered result/error to the response path.
module alu_seq_ctrl #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic               clk,
  input  logic               n_rst,
  alu_seq_ctrl_if.slave      bus,
  output logic               busy,
  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e            state_q, state_d;
  logic [5:0]        sel_q, sel_d;
  logic [15:0]       src1_q, src1_d;
  logic [15:0]       src2_q, src2_d;
  logic [31:0]       res_q, res_d;
  logic [1:0]        err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [5:0]        dec_sel;
  logic              dec_illegal;
  logic              dec_div;
  logic [31:0]       sel_res;
  logic              sel_done;

  always_comb begin
    dec_sel = 6'b000000;
    if (bus.req_dtype == 4'd1 || bus.req_dtype == 4'd2) begin
      case (bus.req_operator)
        5'd1:    dec_sel = 6'b000001;
        5'd2:    dec_sel = 6'b000010;
        5'd3:    dec_sel = (bus.req_dtype == 4'd1) ? 6'b000100 : 6'b010000;
        5'd4:    dec_sel = (bus.req_dtype == 4'd1) ? 6'b001000 : 6'b100000;
        default: dec_sel = 6'b000000;
      endcase
    end
    dec_illegal = (dec_sel == 6'b000000);
    dec_div     = dec_sel[3] | dec_sel[5];
  end

  // sel_q is one-hot, so an OR of the masked slices is the result mux.
  always_comb begin
    sel_res = 32'd0;
    for (int i = 0; i < 6; i++) begin
      if (sel_q[i]) sel_res = sel_res | bus.unit_res[32*i +: 32];
    end
    sel_done = |(bus.unit_done & sel_q);
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    src1_d  = src1_q;
    src2_d  = src2_q;
    res_d   = res_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          src1_d = bus.req_src1;
          src2_d = bus.req_src2;
          sel_d  = dec_sel;
          if (dec_illegal) begin
            err_d   = 2'b01;
            res_d   = 32'd0;
            state_d = S_RESP;
          end else if (dec_div && bus.req_src2 == 16'd0) begin
            err_d   = 2'b10;
            res_d   = 32'd0;
            state_d = S_RESP;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Done is checked first so it wins over a simultaneous timeout.
        if (sel_done) begin
          res_d   = sel_res;
          err_d   = 2'b00;
          state_d = S_RESP;
        end else if (cnt_q == CNT_LAST) begin
          res_d   = 32'd0;
          err_d   = 2'b11;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      src1_q  <= '0;
      src2_q  <= '0;
      res_q   <= '0;
      err_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      src1_q  <= src1_d;
      src2_q  <= src2_d;
      res_q   <= res_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Start is decoded from the state so it falls with the asynchronous reset.
  assign bus.unit_start = (state_q == S_ISSUE) ? sel_q : 6'b000000;
  assign bus.req_ready  = (state_q == S_IDLE);
  assign bus.rsp_valid  = (state_q == S_RESP);
  assign bus.unit_src1  = src1_q;
  assign bus.unit_src2  = src2_q;
  assign bus.rsp_res    = res_q;
  assign bus.rsp_err    = err_q;
  assign busy           = (state_q != S_IDLE);
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl: drives requests and unit done/result lines on
// the falling edge and checks handshake timing, results and error codes.
module tb_alu_seq_ctrl;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       busy;
  logic [1:0] dbg_state;
  int         checks   = 0;
  int         failures = 0;
  logic [31:0] exp_q[$];

  alu_seq_ctrl_if bus();

  alu_seq_ctrl #(.TIMEOUT_CYCLES(64), .CNT_W(7)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .bus       (bus),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Every slice gets a distinct junk value, then the slice under test gets v.
  task automatic load_res(input int idx, input logic [31:0] v);
    for (int i = 0; i < 6; i++) bus.unit_res[32*i +: 32] = 32'hBAD0_0000 | 32'(i);
    bus.unit_res[32*idx +: 32] = v;
  endtask

  task automatic drive_req(input logic [3:0] dt, input logic [4:0] op,
                           input logic [15:0] s1, input logic [15:0] s2);
    bus.req_dtype    = dt;
    bus.req_operator = op;
    bus.req_src1     = s1;
    bus.req_src2     = s2;
    bus.req_valid    = 1'b1;
  endtask

  task automatic do_legal(input string tag, input logic [3:0] dt, input logic [4:0] op,
                          input logic [15:0] s1, input logic [15:0] s2,
                          input logic [5:0] exp_start, input int idx, input int d,
                          input logic [31:0] val);
    load_res(idx, val);
    exp_q.push_back(val);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    drive_req(dt, op, s1, s2);
    chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk({tag, "_start"}, 32'(bus.unit_start), 32'(exp_start));
    chk({tag, "_src1"}, 32'(bus.unit_src1), 32'(s1));
    chk({tag, "_src2"}, 32'(bus.unit_src2), 32'(s2));
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    for (int k = 1; k <= d; k++) begin
      @(negedge clk);
      if (k == 1) chk({tag, "_start_drop"}, 32'(bus.unit_start), 32'd0);
      if (k == d) begin
        chk({tag, "_no_early_valid"}, 32'(bus.rsp_valid), 32'd0);
        bus.unit_done = exp_start;
      end
    end
    @(negedge clk);
    bus.unit_done = 6'b000000;
    chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
    chk({tag, "_rsp_res"}, bus.rsp_res, exp_q.pop_front());
    chk({tag, "_rsp_err"}, 32'(bus.rsp_err), 32'd0);
    @(negedge clk);
    chk({tag, "_valid_drop"}, 32'(bus.rsp_valid), 32'd0);
    chk({tag, "_back_idle"}, 32'(bus.req_ready), 32'd1);
  endtask

  task automatic do_err(input string tag, input logic [3:0] dt, input logic [4:0] op,
                        input logic [15:0] s1, input logic [15:0] s2, input logic [1:0] exp_err);
    load_res(0, 32'h1234_5678);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    drive_req(dt, op, s1, s2);
    chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk({tag, "_no_start"}, 32'(bus.unit_start), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
    chk({tag, "_rsp_err"}, 32'(bus.rsp_err), 32'(exp_err));
    chk({tag, "_rsp_res"}, bus.rsp_res, 32'd0);
    chk({tag, "_src1"}, 32'(bus.unit_src1), 32'(s1));
    @(negedge clk);
    chk({tag, "_valid_drop"}, 32'(bus.rsp_valid), 32'd0);
    chk({tag, "_no_start_after"}, 32'(bus.unit_start), 32'd0);
  endtask

  task automatic do_timeout();
    logic early;
    load_res(3, 32'hCAFE_F00D);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    drive_req(4'd1, 5'd4, 16'h0050, 16'h0005);
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("to_start", 32'(bus.unit_start), 32'b001000);
    bus.unit_done = 6'b001000;  // seen only at the end of the issue cycle
    early = 1'b0;
    for (int k = 1; k <= 64; k++) begin
      @(negedge clk);
      if (k == 1) bus.unit_done = 6'b000000;
      if (k == 5) bus.unit_done = 6'b100000;
      if (k == 6) bus.unit_done = 6'b000000;
      if (bus.rsp_valid) early = 1'b1;
    end
    chk("to_no_early_valid", 32'(early), 32'd0);
    @(negedge clk);
    chk("to_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("to_rsp_err", 32'(bus.rsp_err), 32'd3);
    chk("to_rsp_res", bus.rsp_res, 32'd0);
    @(negedge clk);
    chk("to_valid_drop", 32'(bus.rsp_valid), 32'd0);
  endtask

  task automatic do_backpressure();
    logic stable;
    load_res(0, 32'h0000_0009);
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    drive_req(4'd3, 5'd1, 16'h1111, 16'h2222);
    @(negedge clk);
    drive_req(4'd2, 5'd1, 16'h0004, 16'h0005);
    chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("bp_rsp_err", 32'(bus.rsp_err), 32'd1);
    stable = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 2'b01 || bus.rsp_res !== 32'd0 ||
          bus.req_ready !== 1'b0 || bus.unit_src1 !== 16'h1111) stable = 1'b0;
    end
    chk("bp_stable", 32'(stable), 32'd1);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_valid_drop", 32'(bus.rsp_valid), 32'd0);
    chk("bp_req_ready", 32'(bus.req_ready), 32'd1);
    chk("bp_not_yet_accepted", 32'(bus.unit_src1), 32'h1111);
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("bp_new_start", 32'(bus.unit_start), 32'b000001);
    chk("bp_new_src1", 32'(bus.unit_src1), 32'h0004);
    @(negedge clk);
    bus.unit_done = 6'b000001;
    @(negedge clk);
    bus.unit_done = 6'b000000;
    chk("bp_new_valid", 32'(bus.rsp_valid), 32'd1);
    chk("bp_new_res", bus.rsp_res, 32'h0000_0009);
    @(negedge clk);
  endtask

  task automatic do_reset_mid_wait();
    logic quiet;
    load_res(4, 32'h0001_0000);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    drive_req(4'd2, 5'd3, 16'h0100, 16'h0100);
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("rst_start", 32'(bus.unit_start), 32'b010000);
    @(negedge clk);
    @(negedge clk);
    n_rst = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_unit_start", 32'(bus.unit_start), 32'd0);
    chk("rst_src1", 32'(bus.unit_src1), 32'd0);
    chk("rst_src2", 32'(bus.unit_src2), 32'd0);
    chk("rst_rsp_res", bus.rsp_res, 32'd0);
    chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    bus.unit_done = 6'b010000;
    @(negedge clk);
    n_rst = 1'b1;
    bus.unit_done = 6'b000000;
    quiet = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (bus.rsp_valid !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
    end
    chk("rst_no_response", 32'(quiet), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_rst            = 1'b0;
    bus.req_valid    = 1'b0;
    bus.req_dtype    = 4'd0;
    bus.req_operator = 5'd0;
    bus.req_src1     = 16'd0;
    bus.req_src2     = 16'd0;
    bus.unit_done    = 6'b000000;
    bus.unit_res     = '0;
    bus.rsp_ready    = 1'b0;
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    chk("reset_req_ready", 32'(bus.req_ready), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("reset_unit_start", 32'(bus.unit_start), 32'd0);
    chk("reset_src1", 32'(bus.unit_src1), 32'd0);
    chk("reset_src2", 32'(bus.unit_src2), 32'd0);
    chk("reset_rsp_res", bus.rsp_res, 32'd0);
    chk("reset_rsp_err", 32'(bus.rsp_err), 32'd0);

    do_legal("uadd", 4'd2, 5'd1, 16'h0003, 16'h0004, 6'b000001, 0, 1, 32'h0000_0007);
    do_legal("smul", 4'd1, 5'd3, 16'hFFF6, 16'h0014, 6'b000100, 2, 17, 32'hFFFF_FF38);
    do_legal("udiv", 4'd2, 5'd4, 16'h0064, 16'h0007, 6'b100000, 5, 17, 32'h0000_000E);
    do_legal("sdiv", 4'd1, 5'd4, 16'hFF9C, 16'h0007, 6'b001000, 3, 2, 32'hFFFF_FFF2);
    do_legal("umul", 4'd2, 5'd3, 16'h0100, 16'h0100, 6'b010000, 4, 3, 32'h0001_0000);
    do_legal("ssub_edge", 4'd1, 5'd2, 16'h0005, 16'h0003, 6'b000010, 1, 64, 32'h0000_0002);

    do_err("udiv0", 4'd2, 5'd4, 16'h0064, 16'h0000, 2'b10);
    do_err("sdiv0", 4'd1, 5'd4, 16'h0033, 16'h0000, 2'b10);
    do_err("ill_dtype", 4'd3, 5'd1, 16'h0001, 16'h0002, 2'b01);
    do_err("ill_op5", 4'd1, 5'd5, 16'h0007, 16'h0008, 2'b01);
    do_err("ill_op0", 4'd2, 5'd0, 16'h0009, 16'h000A, 2'b01);

    do_timeout();
    do_backpressure();
    do_reset_mid_wait();
    do_legal("post_rst", 4'd2, 5'd3, 16'h0100, 16'h0100, 6'b010000, 4, 3, 32'h0001_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_seq_ctrl.md
# alu_seq_ctrl

Sequencing controller between the UART command parser and the calculator's arithmetic units (add, subtract, signed/unsigned multiply, signed/unsigned divide). It accepts one parsed request at a time over a valid/ready handshake and latches the operands. It decodes dtype/operator into a one-hot start pulse, waits for the selected unit's done with a timeout, and presents a registered result plus error code to the response path (UART TX formatter) over a second valid/ready handshake.

## Interface
Parameters:
- TIMEOUT_CYCLES, 64: max cycles spent in WAIT before aborting with a timeout error.
- CNT_W, 7: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  single clock, all logic rising-edge.
- n_rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  parser has a request.
- req_ready  out  1  controller can accept; high only in IDLE.
- req_dtype  in  4  1 = signed, 2 = unsigned.
- req_operator  in  5  1 = +, 2 = -, 3 = *, 4 = /.
- req_src1  in  16  operand 1.
- req_src2  in  16  operand 2.
- unit_src1  out  16  latched operand 1 to all units.
- unit_src2  out  16  latched operand 2 to all units.
- unit_start  out  6  one-hot start pulse: bit0 add, bit1 sub, bit2 signed mul, bit3 signed div, bit4 unsigned mul, bit5 unsigned div.
- unit_done  in  6  per-unit done, same bit order.
- unit_res  in  192  per-unit 32-bit results; unit i occupies [32*i+31:32*i].
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_res  out  32  result word.
- rsp_err  out  2  00 ok, 01 illegal op, 10 divide by zero, 11 timeout.
- busy  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, ISSUE, WAIT, RESP. Reset enters IDLE.
- Decode, as (dtype, op) -> unit bit:
  - (1,1) and (2,1) -> 0.
  - (1,2) and (2,2) -> 1.
  - (1,3) -> 2; (1,4) -> 3; (2,3) -> 4; (2,4) -> 5.
  - Any other combination is illegal.
- IDLE:
  - req_ready=1.
  - On req_valid && req_ready: latch src1, src2 and the unit select.
  - If the op is illegal: rsp_err=01, rsp_res=0, go to RESP.
  - Else if the op is a divide (bit 3 or 5) and src2==0: rsp_err=10, rsp_res=0, go to RESP.
  - Else go to ISSUE.
- ISSUE: unit_start[sel]=1 for exactly this cycle; clear the timeout counter; go to WAIT.
- WAIT:
  - If unit_done[sel]: capture unit_res slice sel into rsp_res, rsp_err=00, go to RESP.
  - Else increment the counter; when the counter reaches TIMEOUT_CYCLES-1 without done, set rsp_err=11, rsp_res=0, go to RESP.
  - Done bits of non-selected units are ignored.
- RESP:
  - rsp_valid=1; rsp_res and rsp_err held stable.
  - On rsp_ready, go to IDLE (rsp_valid drops the next cycle).
- unit_src1/unit_src2 hold their latched values until the next accepted request.
- The result is passed through unmodified; the controller performs no arithmetic.

## Timing
- Reset values:
  - req_ready=1 (state IDLE).
  - busy=0, rsp_valid=0.
  - unit_start=0.
  - unit_src1=0, unit_src2=0, rsp_res=0, rsp_err=00.
- Request accept at edge T0. Legal op: ISSUE in cycle T0+1 (start pulse). Earliest done is sampled in T0+2. rsp_valid rises at T0+3 at the earliest.
- Error path (illegal op or divide by zero): rsp_valid high in T0+1; no start pulse issued.
- unit_done asserted during the ISSUE cycle is ignored. Done may be a pulse or a level; only the first WAIT-cycle sample counts.
- Timeout: rsp_valid rises TIMEOUT_CYCLES+1 cycles after the start pulse cycle.
- Done arriving in the same cycle the timeout is reached: done wins, err=00.
- rsp_ready held high continuously: back-to-back requests are accepted every (latency+1) cycles.
- req_valid is ignored outside IDLE; the parser must hold the request.
- Reset mid-operation: immediate return to IDLE. unit_start drops asynchronously, the in-flight result is discarded, and no response is produced.

## Test plan
- Unsigned add: 0x0003 + 0x0004, add done one cycle after start. Required: unit_start=000001 for one cycle, rsp_res=0x00000007, rsp_err=00, rsp_valid at T0+3.
- Signed multiply and unsigned divide 0x0064/0x0007, each unit done after 17 cycles. Required: start bits 2 and 5 respectively, and rsp_res equals the bench-driven unit slice exactly.
- Divide by zero (dtype 2, op 4, src2=0) and illegal op (dtype 3, op 1). Required: no start pulse, rsp_err=10 and 01 respectively, rsp_res=0, rsp_valid at T0+1.
- Unit never asserts done (TIMEOUT_CYCLES=64). Required: rsp_err=11 exactly 65 cycles after the start pulse. A non-selected unit's done pulsed during WAIT must not end the wait.
- Backpressure: rsp_ready held low for 10 cycles. Required: rsp_valid/res/err stable, req_ready=0, and a new req_valid is not accepted until one cycle after rsp_ready.
- n_rst asserted during WAIT. Required: all outputs return to reset values, and the next request after release completes normally.
